// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes R/I-type ALU instructions, reads a 32x32
// register file with writeback bypass, and presents operands in a single-entry output register.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [2:0]  f3;
    logic        is_r;
    logic        is_i;
    logic        legal;
    logic        accept;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_val;
    logic [31:0] r2_next;

    // Handshake: an instruction moves on an edge where instr_valid && instr_ready;
    // an operation leaves on an edge where op_valid && op_ready. The output
    // register can be refilled on the same edge it drains.
    assign instr_ready = !op_valid || op_ready;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        opcode  = instr[6:0];
        rs1_idx = instr[19:15];
        rs2_idx = instr[24:20];
        f3      = instr[14:12];
        is_r    = (opcode == OPC_R);
        is_i    = (opcode == OPC_I);
        legal   = is_r || is_i;

        // Source reads see a same-cycle writeback; x0 is hardwired to zero.
        rs1_val = rf[rs1_idx];
        if (rs1_idx == 5'd0) begin
            rs1_val = '0;
        end else if (wb_en && (wb_rd == rs1_idx)) begin
            rs1_val = wb_data;
        end

        rs2_val = rf[rs2_idx];
        if (rs2_idx == 5'd0) begin
            rs2_val = '0;
        end else if (wb_en && (wb_rd == rs2_idx)) begin
            rs2_val = wb_data;
        end

        // Shifts take an unsigned 5-bit shamt; everything else a signed 12-bit immediate.
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
            imm_val = {27'd0, instr[24:20]};
        end else begin
            imm_val = {{20{instr[31]}}, instr[31:20]};
        end

        r2_next = is_r ? rs2_val : imm_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            illegal  <= 1'b0;
            r1       <= '0;
            r2       <= '0;
            funct3   <= '0;
            rd       <= '0;
        end else begin
            illegal <= accept && !legal;
            if (accept && legal) begin
                op_valid <= 1'b1;
                r1       <= rs1_val;
                r2       <= r2_next;
                funct3   <= f3;
                rd       <= instr[11:7];
            end else if (op_ready) begin
                op_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// compared against an instruction-level reference model and an issue scoreboard.
module tb_alu_issue;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        op_ready = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        instr_ready;
    logic        op_valid;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural register file and the issued operation.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic        m_ill;
    logic        m_issued;
    logic [31:0] m_r1;
    logic [31:0] m_r2;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [71:0] exp_q [$];

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .r1          (r1),
        .r2          (r2),
        .funct3      (funct3),
        .rd          (rd),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] dst);
        return {7'b0, rs2, rs1, f3, dst, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] dst);
        return {imm, rs1, f3, dst, OP_I};
    endfunction

    function automatic logic [31:0] src(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w);
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) return 32'(w[24:20]);
        return 32'($signed(w[31:20]));
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 0; m_ill = 0; m_issued = 0;
        m_r1 = '0; m_r2 = '0; m_f3 = '0; m_rd = '0;
    endtask

    // Predicts the next edge from the current inputs, then advances one clock.
    task automatic tick();
        logic acc, leg, nv, ni;
        logic [31:0] n1, n2;
        logic [2:0] nf;
        logic [4:0] nrd;
        acc = instr_valid && (!m_valid || op_ready);
        leg = (instr[6:0] == OP_R) || (instr[6:0] == OP_I);
        nv = m_valid && !op_ready;
        ni = acc && !leg;
        n1 = m_r1; n2 = m_r2; nf = m_f3; nrd = m_rd;
        m_issued = 0;
        if (acc && leg) begin
            nv = 1; m_issued = 1;
            n1 = src(instr[19:15]);
            n2 = (instr[6:0] == OP_R) ? src(instr[24:20]) : imm_of(instr);
            nf = instr[14:12];
            nrd = instr[11:7];
        end
        if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        m_valid = nv; m_ill = ni; m_r1 = n1; m_r2 = n2; m_f3 = nf; m_rd = nrd;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        reset_model();
        vectors += 7;
        if (op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_op_valid got %0b want 0", op_valid); end
        if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %0b want 0", illegal); end
        if (r1 !== 32'd0) begin miscompares++; $display("FAIL reset_r1 got %h want 0", r1); end
        if (r2 !== 32'd0) begin miscompares++; $display("FAIL reset_r2 got %h want 0", r2); end
        if (funct3 !== 3'd0) begin miscompares++; $display("FAIL reset_funct3 got %0d want 0", funct3); end
        if (rd !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %0d want 0", rd); end
        if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", instr_ready); end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        op_ready = 1; instr_valid = 0;
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_0010; tick();
        wb_rd = 6; wb_data = 32'h0000_0003; tick();
        wb_en = 0;
        instr_valid = 1; instr = enc_r(5'd6, 5'd5, 3'b000, 5'd1); tick();
        vectors += 4;
        if (op_valid !== 1'b1) begin miscompares++; $display("FAIL rtype_valid got %0b want 1", op_valid); end
        if (r1 !== 32'h10) begin miscompares++; $display("FAIL rtype_r1 got %h want 00000010", r1); end
        if (r2 !== 32'h3) begin miscompares++; $display("FAIL rtype_r2 got %h want 00000003", r2); end
        if (funct3 !== 3'b000 || rd !== 5'd1) begin
            miscompares++; $display("FAIL rtype_f3_rd got %0d/%0d want 0/1", funct3, rd);
        end
    endtask

    task automatic test_itype();
        instr = enc_i(12'hFFF, 5'd5, 3'b000, 5'd2); tick();
        vectors += 3;
        if (op_valid !== 1'b1) begin miscompares++; $display("FAIL itype_valid got %0b want 1", op_valid); end
        if (r1 !== 32'h10) begin miscompares++; $display("FAIL itype_r1 got %h want 00000010", r1); end
        if (r2 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL itype_sext got %h want ffffffff", r2); end
        instr = enc_i({7'b0, 5'd31}, 5'd5, 3'b001, 5'd3); tick();
        vectors += 2;
        if (r2 !== 32'h0000_001F) begin miscompares++; $display("FAIL itype_shamt got %h want 0000001f", r2); end
        if (funct3 !== 3'b001) begin miscompares++; $display("FAIL itype_funct3 got %0d want 1", funct3); end
    endtask

    task automatic test_stall();
        instr_valid = 0; op_ready = 1; tick();
        instr_valid = 1; instr = enc_r(5'd6, 5'd5, 3'b000, 5'd9); tick();
        instr = enc_i(12'h123, 5'd6, 3'b100, 5'd12);
        op_ready = 0;
        // A writeback to a held operand's source must not disturb the held operation.
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors += 2;
            if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready cycle %0d got %0b want 0", i, instr_ready); end
            tick();
            wb_en = 0;
            if (op_valid !== 1'b1 || r1 !== 32'h10 || r2 !== 32'h3 || rd !== 5'd9) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d got v=%0b r1=%h r2=%h rd=%0d want v=1 r1=00000010 r2=00000003 rd=9",
                         i, op_valid, r1, r2, rd);
            end
        end
        op_ready = 1;
        #1;
        vectors += 2;
        if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got %0b want 1", instr_ready); end
        tick();
        if (op_valid !== 1'b1 || rd !== 5'd12 || r1 !== 32'h3 || r2 !== 32'h123) begin
            miscompares++;
            $display("FAIL back_to_back got v=%0b rd=%0d r1=%h r2=%h want v=1 rd=12 r1=00000003 r2=00000123",
                     op_valid, rd, r1, r2);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF;
        instr = enc_r(5'd0, 5'd7, 3'b111, 5'd4); tick();
        vectors += 2;
        if (r1 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bypass_rs1 got %h want deadbeef", r1); end
        if (r2 !== 32'd0) begin miscompares++; $display("FAIL bypass_x0_rs2 got %h want 0", r2); end
        wb_rd = 0; wb_data = 32'h1234_5678;
        instr = enc_r(5'd7, 5'd0, 3'b000, 5'd5); tick();
        wb_en = 0;
        vectors += 2;
        if (r1 !== 32'd0) begin miscompares++; $display("FAIL bypass_x0 got %h want 0", r1); end
        if (r2 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL bypass_written got %h want deadbeef", r2); end
    endtask

    task automatic test_illegal();
        instr = {25'd0, 7'b0000011}; tick();
        instr_valid = 0;
        vectors += 2;
        if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_pulse got %0b want 1", illegal); end
        if (op_valid !== 1'b0) begin miscompares++; $display("FAIL illegal_valid got %0b want 0", op_valid); end
        tick();
        vectors++;
        if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_one_cycle got %0b want 0", illegal); end
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        logic [71:0] e;
        int sel;
        instr_valid = 0; op_ready = 1; wb_en = 0; tick();
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) instr = {rnd[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rnd[14:7], OP_R};
            else if (sel < 8) instr = {rnd[31:20], 5'($urandom_range(0, 7)), rnd[14:7], OP_I};
            else begin
                instr = rnd;
                if (rnd[6:0] == OP_R || rnd[6:0] == OP_I) instr[2] = ~rnd[2];
            end
            instr_valid = ($urandom_range(0, 9) < 7);
            op_ready = ($urandom_range(0, 3) != 0);
            wb_en = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1;
            vectors++;
            if (instr_ready !== (!m_valid || op_ready)) begin
                miscompares++; $display("FAIL rand_ready n=%0d got %0b want %0b", n, instr_ready, !m_valid || op_ready);
            end
            if (op_valid && op_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL rand_consume n=%0d got op with empty scoreboard want none", n);
                end else begin
                    e = exp_q.pop_front();
                    if ({funct3, rd, r1, r2} !== e) begin
                        miscompares++;
                        $display("FAIL rand_op n=%0d got %h want %h", n, {funct3, rd, r1, r2}, e);
                    end
                end
            end
            tick();
            if (m_issued) exp_q.push_back({m_f3, m_rd, m_r1, m_r2});
            vectors += 2;
            if (op_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid n=%0d got %0b want %0b", n, op_valid, m_valid); end
            if (illegal !== m_ill) begin miscompares++; $display("FAIL rand_illegal n=%0d got %0b want %0b", n, illegal, m_ill); end
        end
        instr_valid = 0; op_ready = 1; wb_en = 0;
        if (op_valid) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
            vectors++;
            if ({funct3, rd, r1, r2} !== e) begin miscompares++; $display("FAIL rand_drain got %h want %h", {funct3, rd, r1, r2}, e); end
        end
        tick();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        op_ready = 1; instr_valid = 1;
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_0077;
        instr = enc_r(5'd0, 5'd5, 3'b000, 5'd3); tick();
        op_ready = 0; instr_valid = 0; wb_en = 0; tick();
        vectors++;
        if (op_valid !== 1'b1 || r1 !== 32'h77) begin
            miscompares++; $display("FAIL areset_setup got v=%0b r1=%h want v=1 r1=00000077", op_valid, r1);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (op_valid !== 1'b0 || r1 !== 32'd0) begin
            miscompares++; $display("FAIL areset_async got v=%0b r1=%h want v=0 r1=0", op_valid, r1);
        end
        if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL areset_ready got %0b want 1", instr_ready); end
        reset_model();
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_0099;
        instr_valid = 1; instr = enc_r(5'd5, 5'd5, 3'b000, 5'd8);
        @(posedge clk);
        #1;
        vectors++;
        if (op_valid !== 1'b0) begin miscompares++; $display("FAIL areset_no_accept got %0b want 0", op_valid); end
        rst_n = 1'b1;
        wb_en = 0; op_ready = 1;
        instr = enc_r(5'd5, 5'd5, 3'b000, 5'd4); tick();
        vectors += 2;
        if (op_valid !== 1'b1) begin miscompares++; $display("FAIL areset_first_issue got %0b want 1", op_valid); end
        if (r1 !== 32'd0 || r2 !== 32'd0) begin
            miscompares++; $display("FAIL areset_x5_cleared got r1=%h r2=%h want 0/0", r1, r2);
        end
        instr_valid = 0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_stall();
        test_bypass();
        test_illegal();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
